// File: rtl/plsgen_pkg.sv
// Shared encodings and parameter bounds for the edge-to-pulse generator.
package plsgen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int CH_MIN       = 1;
    localparam int CH_MAX       = 32;
    localparam int SYNC_STG_MAX = 3;
    localparam int PLS_W_MIN    = 1;
    localparam int PLS_W_MAX    = 255;

    function automatic logic edge_sel(input logic [1:0] mode, input logic rise, input logic fall);
        case (mode_e'(mode))
            MODE_RISE: return rise;
            MODE_FALL: return fall;
            MODE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_plsgen_ch.sv
// One channel: optional synchroniser, edge qualify, pulse-stretch counter, sticky overrun.
module plsgen_ch
    import plsgen_pkg::*;
#(
    parameter int SYNC_STG = 2,
    parameter int PLS_W    = 1,
    parameter int RETRIG   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       primed,
    input  logic [1:0] mode,
    input  logic       din,
    input  logic       ovf_clr,
    output logic       pls,
    output logic       ovf
);
    localparam int             CW       = $clog2(PLS_W + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(PLS_W);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam bit             RT       = (RETRIG != 0);

    logic          s, p;
    logic [CW-1:0] cnt, cnt_next;
    logic          edge_q, ovf_set;

    generate
        if (SYNC_STG == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [SYNC_STG-1:0] sync;
            always_ff @(posedge clk) begin
                if (rst) sync <= '0;
                else     sync <= SYNC_STG'({sync, din});
            end
            assign s = sync[SYNC_STG-1];
        end
    endgenerate

    // cnt <= 1 means the pulse ends this cycle, so a reload keeps pls high with no gap
    always_comb begin
        edge_q   = primed & en & edge_sel(mode, s & ~p, ~s & p);
        ovf_set  = 1'b0;
        cnt_next = cnt;
        if (edge_q && (cnt <= CNT_ONE || RT)) begin
            cnt_next = CNT_LOAD;
        end else begin
            ovf_set = edge_q;
            if (cnt != '0) cnt_next = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= 1'b0;
            cnt <= '0;
            pls <= 1'b0;
            ovf <= 1'b0;
        end else begin
            p   <= s;
            cnt <= cnt_next;
            pls <= (cnt_next != '0);
            ovf <= ovf_set | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: rtl/edge_plsgen.sv
// Multi-channel edge-to-pulse generator: CH channel instances plus a shared prime counter.
module edge_plsgen
    import plsgen_pkg::*;
#(
    parameter int CH       = 4,
    parameter int SYNC_STG = 2,
    parameter int PLS_W    = 1,
    parameter int RETRIG   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   din,
    input  logic [CH-1:0]   ovf_clr,
    output logic [CH-1:0]   pls,
    output logic [CH-1:0]   ovf
);
    localparam int            PW      = 3;
    localparam logic [PW-1:0] PRIME_N = PW'(SYNC_STG + 1);

    generate
        if (CH < CH_MIN || CH > CH_MAX) begin : g_bad_ch
            $error("edge_plsgen: CH out of range");
        end
        if (SYNC_STG < 0 || SYNC_STG > SYNC_STG_MAX) begin : g_bad_sync
            $error("edge_plsgen: SYNC_STG out of range");
        end
        if (PLS_W < PLS_W_MIN || PLS_W > PLS_W_MAX) begin : g_bad_w
            $error("edge_plsgen: PLS_W out of range");
        end
        if (RETRIG != 0 && RETRIG != 1) begin : g_bad_rt
            $error("edge_plsgen: RETRIG must be 0 or 1");
        end
    endgenerate

    // Hold off edge detection until the sync chain and p hold post-reset samples
    logic [PW-1:0] prime_cnt;
    logic          primed;

    assign primed = (prime_cnt == PRIME_N);

    always_ff @(posedge clk) begin
        if (rst)          prime_cnt <= '0;
        else if (!primed) prime_cnt <= prime_cnt + PW'(1);
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            plsgen_ch #(
                .SYNC_STG (SYNC_STG),
                .PLS_W    (PLS_W),
                .RETRIG   (RETRIG)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .primed   (primed),
                .mode     (mode[2*i +: 2]),
                .din      (din[i]),
                .ovf_clr  (ovf_clr[i]),
                .pls      (pls[i]),
                .ovf      (ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_plsgen.sv
// Four differently-parameterised edge_plsgen instances driven by shared stimulus,
// checked against a deadline-based reference model, a vector table and counted sequences.
module tb_edge_plsgen;
    localparam int NI   = 4;
    localparam int MAXN = 4000;
    localparam int S_P [NI] = '{2, 2, 0, 1};
    localparam int W_P [NI] = '{1, 5, 5, 4};
    localparam int R_P [NI] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] mode = 8'h00;
    logic [3:0] din = 4'h0;
    logic [3:0] ovf_clr = 4'h0;
    logic [3:0] pls_a, pls_b, pls_c, pls_d, ovf_a, ovf_b, ovf_c, ovf_d;
    logic [3:0] pls_v [NI];
    logic [3:0] ovf_v [NI];

    always #5 clk = ~clk;

    edge_plsgen #(.CH(4), .SYNC_STG(2), .PLS_W(1), .RETRIG(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .ovf_clr(ovf_clr), .pls(pls_a), .ovf(ovf_a));
    edge_plsgen #(.CH(4), .SYNC_STG(2), .PLS_W(5), .RETRIG(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .ovf_clr(ovf_clr), .pls(pls_b), .ovf(ovf_b));
    edge_plsgen #(.CH(4), .SYNC_STG(0), .PLS_W(5), .RETRIG(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .ovf_clr(ovf_clr), .pls(pls_c), .ovf(ovf_c));
    edge_plsgen #(.CH(4), .SYNC_STG(1), .PLS_W(4), .RETRIG(0)) u_d (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .ovf_clr(ovf_clr), .pls(pls_d), .ovf(ovf_d));

    assign pls_v[0] = pls_a;
    assign pls_v[1] = pls_b;
    assign pls_v[2] = pls_c;
    assign pls_v[3] = pls_d;
    assign ovf_v[0] = ovf_a;
    assign ovf_v[1] = ovf_b;
    assign ovf_v[2] = ovf_c;
    assign ovf_v[3] = ovf_d;

    int ncmp = 0;
    int nerr = 0;
    int n    = 0;
    int r_t  = 0;

    // Input history indexed by the clock edge that sampled it
    logic [3:0] din_at  [MAXN];
    logic       en_at   [MAXN];
    logic [7:0] mode_at [MAXN];
    logic [3:0] clr_at  [MAXN];

    // Model state: pulse is high for edge indices below pend
    int  pend  [NI][4];
    bit  m_ovf [NI][4];
    int  hi_cnt [NI][4];
    int  rs_cnt [NI][4];
    bit  prev_p [NI][4];

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] mode;
        logic [3:0] din;
        logic [3:0] exp_pls;
    } vec_t;
    vec_t tbl [26];

    task automatic chk(input string nm, input int inst, input logic [3:0] act, input logic [3:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s inst%0d edge=%0d got=%b want=%b", nm, inst, n, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", nm, n, act, exp);
        end
    endtask

    task automatic model_step();
        bit a, b, q, set;
        logic [1:0] md;
        if (rst) begin
            r_t = n;
            for (int i = 0; i < NI; i++)
                for (int c = 0; c < 4; c++) begin
                    pend[i][c]  = 0;
                    m_ovf[i][c] = 1'b0;
                end
            return;
        end
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) begin
                q = 1'b0;
                set = 1'b0;
                if (n - r_t >= S_P[i] + 2) begin
                    a  = din_at[n - S_P[i]][c];
                    b  = din_at[n - S_P[i] - 1][c];
                    md = mode_at[n][2*c +: 2];
                    q  = en_at[n] && ((md == 2'b01 && a && !b) || (md == 2'b10 && !a && b) ||
                                      (md == 2'b11 && a != b));
                end
                if (q) begin
                    if (pend[i][c] <= n || R_P[i] != 0) pend[i][c] = n + W_P[i];
                    else                                 set = 1'b1;
                end
                if (set)                 m_ovf[i][c] = 1'b1;
                else if (clr_at[n][c])   m_ovf[i][c] = 1'b0;
            end
    endtask

    task automatic tick();
        logic [3:0] ep, eo;
        @(posedge clk);
        n++;
        if (n >= MAXN) begin
            $display("FAIL cycle_budget edge=%0d limit=%0d", n, MAXN);
            nerr++;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
            $fatal(1);
        end
        din_at[n]  = din;
        en_at[n]   = en;
        mode_at[n] = mode;
        clr_at[n]  = ovf_clr;
        model_step();
        #1;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 4; c++) begin
                ep[c] = (n < pend[i][c]);
                eo[c] = m_ovf[i][c];
                if (pls_v[i][c] === 1'b1) hi_cnt[i][c]++;
                if (pls_v[i][c] === 1'b1 && !prev_p[i][c]) rs_cnt[i][c]++;
                prev_p[i][c] = (pls_v[i][c] === 1'b1);
            end
            chk("model_pls", i, pls_v[i], ep);
            chk("model_ovf", i, ovf_v[i], eo);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) begin
                hi_cnt[i][c] = 0;
                rs_cnt[i][c] = 0;
            end
    endtask

    task automatic drive(input logic [3:0] d, input int k);
        din = d;
        repeat (k) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ovf_clr = 4'h0;
        din = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] m, input logic [3:0] d, input logic [3:0] e);
        vec_t v;
        v.rst = r; v.en = 1'b1; v.mode = m; v.din = d; v.exp_pls = e;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) begin
                pend[i][c] = 0; m_ovf[i][c] = 1'b0; prev_p[i][c] = 1'b0;
            end
        clr_counts();

        // Instance A (SYNC_STG=2, PLS_W=1): priming, then mode decode with {off,rise,fall,both}
        tbl[0] = mk(1, 8'hFF, 4'hF, 4'h0);
        tbl[1] = mk(1, 8'hFF, 4'hF, 4'h0);
        for (int k = 2; k <= 6; k++) tbl[k] = mk(0, 8'hFF, 4'hF, 4'h0);
        tbl[7]  = mk(0, 8'hFF, 4'hE, 4'h0);
        tbl[8]  = mk(0, 8'hFF, 4'hE, 4'h0);
        tbl[9]  = mk(0, 8'hFF, 4'hE, 4'h1);
        tbl[10] = mk(0, 8'hFF, 4'hE, 4'h0);
        tbl[11] = mk(0, 8'hFF, 4'hE, 4'h0);
        for (int k = 12; k <= 14; k++) tbl[k] = mk(0, 8'h00, 4'h0, 4'h0);
        tbl[15] = mk(0, 8'h1B, 4'h0, 4'h0);
        tbl[16] = mk(0, 8'h1B, 4'h0, 4'h0);
        tbl[17] = mk(0, 8'h1B, 4'hF, 4'h0);
        tbl[18] = mk(0, 8'h1B, 4'hF, 4'h0);
        tbl[19] = mk(0, 8'h1B, 4'hF, 4'h5);
        tbl[20] = mk(0, 8'h1B, 4'hF, 4'h0);
        tbl[21] = mk(0, 8'h1B, 4'h0, 4'h0);
        tbl[22] = mk(0, 8'h1B, 4'h0, 4'h0);
        tbl[23] = mk(0, 8'h1B, 4'h0, 4'h3);
        tbl[24] = mk(0, 8'h1B, 4'h0, 4'h0);
        tbl[25] = mk(0, 8'h1B, 4'h0, 4'h0);

        for (int k = 0; k < 26; k++) begin
            rst = tbl[k].rst; en = tbl[k].en; mode = tbl[k].mode; din = tbl[k].din;
            tick();
            chk("tbl_pls", 0, pls_a, tbl[k].exp_pls);
            if (k == 0) chk("reset_ovf", 0, ovf_a, 4'h0);
        end

        // Rises 3 apart: B drops the second (ovf), C retriggers into 8 contiguous cycles
        mode = 8'h55;
        do_reset();
        clr_counts();
        drive(4'h1, 1); drive(4'h0, 2); drive(4'h1, 1); drive(4'h0, 14);
        chk_i("ovr_b_hi", hi_cnt[1][0], 5);
        chk_i("ovr_b_rises", rs_cnt[1][0], 1);
        chk_i("ovr_b_ovf", int'(ovf_b[0]), 1);
        chk_i("rtg_c_hi", hi_cnt[2][0], 8);
        chk_i("rtg_c_rises", rs_cnt[2][0], 1);
        chk_i("rtg_c_ovf", int'(ovf_c[0]), 0);

        // ovf_clr coincident with a new overrun on B, then a lone clear
        drive(4'h1, 1); drive(4'h0, 2); drive(4'h1, 1); drive(4'h0, 1);
        ovf_clr = 4'h1;
        drive(4'h0, 1);
        ovf_clr = 4'h0;
        chk_i("clr_vs_set_b", int'(ovf_b[0]), 1);
        drive(4'h0, 10);
        ovf_clr = 4'h1;
        drive(4'h0, 1);
        ovf_clr = 4'h0;
        chk_i("lone_clr_b", int'(ovf_b[0]), 0);

        // D (PLS_W=4): spacing 4 merges, spacing 5 leaves a one-cycle gap
        do_reset();
        clr_counts();
        drive(4'h1, 1); drive(4'h0, 3); drive(4'h1, 1); drive(4'h0, 12);
        chk_i("bnd4_d_hi", hi_cnt[3][0], 8);
        chk_i("bnd4_d_rises", rs_cnt[3][0], 1);
        chk_i("bnd4_d_ovf", int'(ovf_d[0]), 0);
        clr_counts();
        drive(4'h1, 1); drive(4'h0, 4); drive(4'h1, 1); drive(4'h0, 12);
        chk_i("bnd5_d_hi", hi_cnt[3][0], 8);
        chk_i("bnd5_d_rises", rs_cnt[3][0], 2);

        // en dropped mid-pulse: pulse completes, later rises ignored
        do_reset();
        clr_counts();
        drive(4'h1, 1); drive(4'h0, 2);
        en = 1'b0;
        drive(4'h1, 1); drive(4'h0, 2); drive(4'h1, 1); drive(4'h0, 10);
        en = 1'b1;
        chk_i("en_b_hi", hi_cnt[1][0], 5);
        chk_i("en_b_rises", rs_cnt[1][0], 1);
        chk_i("en_b_ovf", int'(ovf_b[0]), 0);

        // rst mid-pulse with ovf set
        do_reset();
        drive(4'h1, 1); drive(4'h0, 2); drive(4'h1, 1); drive(4'h0, 2);
        chk_i("pre_rst_b_pls", int'(pls_b[0]), 1);
        chk_i("pre_rst_b_ovf", int'(ovf_b[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_pls", 1, pls_b, 4'h0);
        chk("rst_mid_ovf", 1, ovf_b, 4'h0);

        // Randomised traffic against the model
        for (int k = 0; k < 2500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom_range(0, 255));
            din = din ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            ovf_clr = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
